// File: rtl/dbus_pkg.sv
// Shared data-bus definitions: widths, arbiter state, master id, payload
// struct and the memory/I/O region decode helper.
package dbus_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned WEN_W  = 2;
  localparam int unsigned NUM_M  = 2;
  localparam int unsigned CNT_W  = 4;

  localparam logic [ADDR_W-1:0] MEMADDRBASE_DEF  = 16'h2000;
  localparam int unsigned       STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    FREE,
    LOCK0,
    LOCK1
  } arb_state_t;

  typedef logic master_id_t;

  // One master's outgoing transaction payload.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [WEN_W-1:0]  wen;
  } bus_req_t;

  // Addresses at or above base belong to memory, below it to I/O.
  function automatic logic region_is_mem(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] base);
    return addr >= base;
  endfunction

endpackage

// File: rtl/dbus_if.sv
// Data-bus bundle between the two masters, the arbiter and the slaves.
// slave modport  : arbiter view (requests/addresses/slave data in, grants/bus out).
// master modport : environment view (masters and slaves), directions reversed.
interface dbus_if;
  import dbus_pkg::*;

  logic [NUM_M-1:0]  m_req;
  logic [NUM_M-1:0]  m_lock;
  logic [ADDR_W-1:0] m0_addr;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m1_wdata;
  logic [WEN_W-1:0]  m0_wen;
  logic [WEN_W-1:0]  m1_wen;
  logic [NUM_M-1:0]  m_gnt;
  logic [NUM_M-1:0]  m_rvalid;
  logic [DATA_W-1:0] m_rdata;
  logic [ADDR_W-1:0] dread_addr;
  logic [ADDR_W-1:0] dwrite_addr;
  logic [DATA_W-1:0] dwrite_data;
  logic [WEN_W-1:0]  mem_dwrite_en;
  logic [WEN_W-1:0]  io_dwrite_en;
  logic [DATA_W-1:0] mem_dread_data;
  logic [DATA_W-1:0] io_dread_data;

  modport slave (
    input  m_req, m_lock, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wen, m1_wen,
    input  mem_dread_data, io_dread_data,
    output m_gnt, m_rvalid, m_rdata, dread_addr, dwrite_addr, dwrite_data,
    output mem_dwrite_en, io_dwrite_en
  );

  modport master (
    output m_req, m_lock, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_wen, m1_wen,
    output mem_dread_data, io_dread_data,
    input  m_gnt, m_rvalid, m_rdata, dread_addr, dwrite_addr, dwrite_data,
    input  mem_dwrite_en, io_dwrite_en
  );

endinterface

// File: rtl/dbus_rr_starve.sv
// Starvation tracker for master 1: counts consecutive refused request cycles
// and raises force1 once the count has reached STARVE_LIMIT.
// Ports: clk, reset (async active-high), req1/gnt1 (master 1 request/grant),
//        force1 (master 1 must win this cycle when the bus is free).
module dbus_rr_starve
  import dbus_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req1,
  input  logic gnt1,
  output logic force1
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] cnt_next;

  // Count refusals, saturating; any grant or idle request clears it.
  always_comb begin
    cnt_next = starve_cnt;
    if (!req1 || gnt1) begin
      cnt_next = '0;
    end else if (starve_cnt != LIMIT) begin
      cnt_next = starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else begin
      starve_cnt <= cnt_next;
    end
  end

  assign force1 = req1 && (starve_cnt == LIMIT);

endmodule

// File: rtl/dbus_arbiter.sv
// Two-master data-bus arbiter: CPU-favoured fixed priority with a starvation
// override for master 1, per-master bus lock, region-split write enables and
// one-cycle read-data return.
// Ports: clk, reset (async active-high), bus (dbus_if.slave: master requests,
//        locks, payloads and slave read data in; grants, shared bus, decoded
//        write enables, rvalid/rdata out).
module dbus_arbiter
  import dbus_pkg::*;
#(
  parameter logic [ADDR_W-1:0] MEMADDRBASE  = MEMADDRBASE_DEF,
  parameter int unsigned       STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic    clk,
  input  logic    reset,
  dbus_if.slave   bus
);

  arb_state_t       state;
  arb_state_t       state_next;
  logic [NUM_M-1:0] gnt;
  logic             force1;
  master_id_t       owner;
  bus_req_t         req_m0;
  bus_req_t         req_m1;
  bus_req_t         sel;
  logic             txn;
  logic             rd_txn;
  logic             sel_mem;
  logic [NUM_M-1:0] rvalid;
  logic             rd_mem;

  dbus_rr_starve #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .reset  (reset),
    .req1   (bus.m_req[1]),
    .gnt1   (gnt[1]),
    .force1 (force1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FREE;
    end else begin
      state <= state_next;
    end
  end

  // Grant selection and lock transitions.
  always_comb begin
    gnt        = '0;
    state_next = state;
    case (state)
      FREE: begin
        if (force1) begin
          gnt = 2'b10;
        end else if (bus.m_req[0]) begin
          gnt = 2'b01;
        end else if (bus.m_req[1]) begin
          gnt = 2'b10;
        end
      end
      LOCK0:   gnt = {1'b0, bus.m_req[0]};
      LOCK1:   gnt = {bus.m_req[1], 1'b0};
      default: gnt = '0;
    endcase
    if (reset) begin
      gnt = '0;
    end

    case (state)
      FREE: begin
        if (gnt[0] && bus.m_lock[0]) begin
          state_next = LOCK0;
        end else if (gnt[1] && bus.m_lock[1]) begin
          state_next = LOCK1;
        end
      end
      LOCK0:   if (!bus.m_lock[0]) state_next = FREE;
      LOCK1:   if (!bus.m_lock[1]) state_next = FREE;
      default: state_next = FREE;
    endcase
  end

  // With no grant the mux falls back to master 0's payload.
  assign req_m0  = '{addr: bus.m0_addr, wdata: bus.m0_wdata, wen: bus.m0_wen};
  assign req_m1  = '{addr: bus.m1_addr, wdata: bus.m1_wdata, wen: bus.m1_wen};
  assign owner   = gnt[1];
  assign sel     = owner ? req_m1 : req_m0;
  assign txn     = |gnt;
  assign rd_txn  = txn && (sel.wen == '0);
  assign sel_mem = region_is_mem(sel.addr, MEMADDRBASE);

  assign bus.m_gnt         = gnt;
  assign bus.dread_addr    = sel.addr;
  assign bus.dwrite_addr   = sel.addr;
  assign bus.dwrite_data   = sel.wdata;
  assign bus.mem_dwrite_en = (txn && sel_mem)  ? sel.wen : '0;
  assign bus.io_dwrite_en  = (txn && !sel_mem) ? sel.wen : '0;

  // Remember who read and from which region for next cycle's return.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= '0;
      rd_mem <= 1'b0;
    end else begin
      rvalid <= rd_txn ? (owner ? 2'b10 : 2'b01) : 2'b00;
      rd_mem <= rd_txn && sel_mem;
    end
  end

  assign bus.m_rvalid = rvalid;
  assign bus.m_rdata  = rd_mem ? bus.mem_dread_data : bus.io_dread_data;

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;

  localparam logic [15:0] BASE  = 16'h2000;
  localparam int          LIMIT = 4;

  logic clk;
  logic reset;

  dbus_if bus();

  dbus_arbiter #(
    .MEMADDRBASE  (BASE),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: lock owner (-1 = free), refusal count, pending read.
  int mdl_lock;
  int mdl_cnt;
  bit pend_valid;
  int pend_owner;
  bit pend_mem;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mdl_lock   = -1;
    mdl_cnt    = 0;
    pend_valid = 1'b0;
    pend_owner = 0;
    pend_mem   = 1'b0;
  endtask

  // One bus cycle: drive, check combinational and registered outputs, clock, update model.
  task automatic cycle(input logic [1:0] req, input logic [1:0] lock,
                       input logic [15:0] a0, input logic [15:0] d0, input logic [1:0] w0,
                       input logic [15:0] a1, input logic [15:0] d1, input logic [1:0] w1,
                       input logic [15:0] memd, input logic [15:0] iod);
    int          g;
    logic [15:0] ea;
    logic [15:0] ed;
    logic [1:0]  ew;
    bit          emem;
    bus.m_req = req;        bus.m_lock = lock;
    bus.m0_addr = a0;       bus.m0_wdata = d0;  bus.m0_wen = w0;
    bus.m1_addr = a1;       bus.m1_wdata = d1;  bus.m1_wen = w1;
    bus.mem_dread_data = memd;
    bus.io_dread_data  = iod;
    #4;
    g = -1;
    if (mdl_lock >= 0) begin
      if (req[mdl_lock]) g = mdl_lock;
    end else if (mdl_cnt == LIMIT && req[1]) g = 1;
    else if (req[0]) g = 0;
    else if (req[1]) g = 1;
    ea   = (g == 1) ? a1 : a0;
    ed   = (g == 1) ? d1 : d0;
    ew   = (g < 0) ? 2'b00 : ((g == 1) ? w1 : w0);
    emem = (ea >= BASE);
    chk("gnt",         32'(bus.m_gnt), (g < 0) ? 32'd0 : 32'(1 << g));
    chk("dread_addr",  32'(bus.dread_addr), 32'(ea));
    chk("dwrite_addr", 32'(bus.dwrite_addr), 32'(ea));
    chk("dwrite_data", 32'(bus.dwrite_data), 32'(ed));
    chk("mem_wen",     32'(bus.mem_dwrite_en), emem ? 32'(ew) : 32'd0);
    chk("io_wen",      32'(bus.io_dwrite_en), emem ? 32'd0 : 32'(ew));
    chk("rvalid",      32'(bus.m_rvalid), pend_valid ? 32'(1 << pend_owner) : 32'd0);
    chk("rdata",       32'(bus.m_rdata), pend_mem ? 32'(memd) : 32'(iod));
    chk("starve_cnt",  32'(dut.u_starve.starve_cnt), 32'(mdl_cnt));
    @(posedge clk);
    #1;
    if (mdl_lock >= 0) begin
      if (!lock[mdl_lock]) mdl_lock = -1;
    end else if (g >= 0 && lock[g]) mdl_lock = g;
    if (req[1] && g != 1) mdl_cnt = (mdl_cnt < LIMIT) ? mdl_cnt + 1 : LIMIT;
    else mdl_cnt = 0;
    pend_valid = (g >= 0) && (ew == 2'b00);
    pend_owner = (g < 0) ? 0 : g;
    pend_mem   = pend_valid && emem;
  endtask

  // Asynchronous reset pulse starting mid-cycle; outputs must drop at once.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst_gnt",     32'(bus.m_gnt), 32'd0);
    chk("rst_rvalid",  32'(bus.m_rvalid), 32'd0);
    chk("rst_mem_wen", 32'(bus.mem_dwrite_en), 32'd0);
    chk("rst_io_wen",  32'(bus.io_dwrite_en), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_clear();
  endtask

  function automatic logic [15:0] rnd_addr();
    case ($urandom_range(0, 3))
      0:       return BASE - 16'd1;
      1:       return BASE;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic logic [1:0] rnd_wen();
    return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
  endfunction

  initial begin
    reset = 1'b1;
    bus.m_req = '0;  bus.m_lock = '0;
    bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wen = '0;
    bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wen = '0;
    bus.mem_dread_data = '0; bus.io_dread_data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt",    32'(bus.m_gnt), 32'd0);
    chk("reset_rvalid", 32'(bus.m_rvalid), 32'd0);
    chk("reset_cnt",    32'(dut.u_starve.starve_cnt), 32'd0);
    reset = 1'b0;

    // CPU-only read from memory, data returned next cycle.
    cycle(2'b01, 2'b00, 16'h2004, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0000, 16'h0000);
    cycle(2'b00, 2'b00, 16'h0000, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 16'hBEEF, 16'h1234);

    // Master 1 writes just below and exactly at the region boundary.
    cycle(2'b10, 2'b00, 16'h0, 16'h0, 2'b00, 16'h1FFE, 16'hA5A5, 2'b11, 16'h0, 16'h0);
    cycle(2'b10, 2'b00, 16'h0, 16'h0, 2'b00, 16'h2000, 16'h5A5A, 2'b11, 16'h0, 16'h0);

    // Both masters request continuously: starvation override every fifth cycle.
    repeat (11) cycle(2'b11, 2'b00, 16'h3000, 16'h1111, 2'b01, 16'h0100, 16'h2222, 2'b10,
                      16'($urandom), 16'($urandom));

    // Master 1 locks, holds through contention, then releases.
    cycle(2'b10, 2'b10, 16'h0, 16'h0, 2'b00, 16'h4000, 16'h0, 2'b00, 16'h0, 16'h0);
    repeat (3) cycle(2'b11, 2'b10, 16'h0010, 16'h0, 2'b11, 16'h4002, 16'h77, 2'b11, 16'h0, 16'h0);
    cycle(2'b11, 2'b00, 16'h0010, 16'h0, 2'b00, 16'h4004, 16'h0, 2'b00, 16'h0, 16'h0);
    cycle(2'b11, 2'b00, 16'h0010, 16'h0, 2'b00, 16'h4004, 16'h0, 2'b00, 16'h0, 16'h0);

    // Back-to-back reads: m0 from I/O, then m1 from memory.
    cycle(2'b01, 2'b00, 16'h0100, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
    cycle(2'b10, 2'b00, 16'h0, 16'h0, 2'b00, 16'h3000, 16'h0, 2'b00, 16'h9999, 16'hAAAA);
    cycle(2'b00, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h5555, 16'h6666);

    // LOCK0 suppresses the override while the count saturates; release lets m1 in.
    cycle(2'b01, 2'b01, 16'h2100, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
    repeat (7) cycle(2'b11, 2'b01, 16'h2100, 16'h3, 2'b01, 16'h0200, 16'h4, 2'b10,
                     16'($urandom), 16'($urandom));
    cycle(2'b11, 2'b00, 16'h2100, 16'h0, 2'b00, 16'h0200, 16'h0, 2'b00, 16'h0, 16'h0);
    cycle(2'b11, 2'b00, 16'h2100, 16'h0, 2'b00, 16'h0200, 16'h0, 2'b00, 16'h0, 16'h0);

    // Reset while in LOCK0 with a read outstanding.
    cycle(2'b01, 2'b01, 16'h0200, 16'h0, 2'b00, 16'h0, 16'h0, 2'b00, 16'h0, 16'h0);
    pulse_reset();
    cycle(2'b11, 2'b00, 16'h0300, 16'h0, 2'b00, 16'h2300, 16'h0, 2'b00, 16'h0, 16'h0);

    // Randomized traffic against the model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) pulse_reset();
      cycle(2'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00,
            rnd_addr(), 16'($urandom), rnd_wen(),
            rnd_addr(), 16'($urandom), rnd_wen(),
            16'($urandom), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
